regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Write-back scheduler for the 32x32 register file's single write port. Two producers present destination/data pairs through valid/ready handshakes: ALU results and memory load data. Each producer has its own queue. A round-robin arbiter drains one entry per cycle onto the regfile write port (writereg/writedata/regwrite). A per-register pending vector is exported for hazard detection.

Parameters:
DEPTH, 2, entries per producer queue; power of 2, minimum 2.
DATA_W, 32, write data width; must match the register file.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
alu_valid  in  1  ALU write-back request.
alu_ready  out  1  ALU queue can accept.
alu_reg  in  5  ALU destination register.
alu_data  in  DATA_W  ALU result.
mem_valid  in  1  load write-back request.
mem_ready  out  1  load queue can accept.
mem_reg  in  5  load destination register.
mem_data  in  DATA_W  load data.
writereg  out  5  to regfile writereg.
writedata  out  DATA_W  to regfile writedata.
regwrite  out  1  to regfile regwrite.
pending  out  32  bit r = 1 while a write to r is queued or on the write port.
idle  out  1  both queues empty and regwrite low.

Behaviour:
- Reset, synchronous: queues emptied; writereg=0, writedata=0, regwrite=0; last_grant=MEM, so the ALU wins the first tie.
- While reset is high: alu_ready=mem_ready=0 and pushes are ignored. The cycle after reset deasserts, both ready=1, pending=0, idle=1.
- Reset mid-operation: all queued entries are discarded and no further regwrite is issued for them.
- Push: an entry is written into the producer's queue at the posedge where valid && ready.
- ready = !full, computed from registered occupancy only. A full queue does not accept a push even when it pops in the same cycle.
- Each producer's queue is FIFO, and that producer's writes reach the port in the order they were accepted.
- Arbitration, evaluated each cycle on registered queue state:
  - Neither queue non-empty: no grant.
  - One queue non-empty: that queue is granted.
  - Both non-empty: the producer not equal to last_grant is granted, and last_grant updates to the winner.
- Grant at edge N:
  - The head entry is popped.
  - writereg and writedata load the head's reg and data.
  - regwrite=1, except when the head's reg==0. In that case regwrite=0 and the entry is still consumed (write to R0 is dropped).
- No grant at edge N: regwrite=0; writereg and writedata hold their previous values.
- Latency: accepted at edge N, empty queue, no contention -> popped at edge N+1. regwrite is high for exactly one cycle, from edge N+1 to N+2, so the regfile's negedge write lands within that cycle.
- Sustained throughput: one write per cycle total. Under continuous contention the two producers alternate.
- Push and pop on the same queue in the same cycle: occupancy is unchanged. A push to an empty queue is not popped in the same cycle.
- pending:
  - Combinational OR over valid queue entries (both queues) and the port stage when regwrite=1.
  - pending[0] is always 0.
  - Duplicates of the same register keep the bit set until the last matching write leaves.
- Occupancy counters are log2(DEPTH)+1 bits and pointers wrap modulo DEPTH.

Optional Feature:
WB_MEM_PRIO_EN:
- Defined: fixed priority; MEM is granted whenever its queue is non-empty and last_grant is unused. ALU may starve while loads stream.
- Undefined: round-robin as described above.

Test Plan:
- Reset then single push alu_reg=5, alu_data=0xDEADBEEF at edge 1 -> at edge 2 writereg=5, writedata=0xDEADBEEF, regwrite=1 for one cycle; pending[5]=1 from edge 1 until edge 3; idle=1 after edge 3.
- Both producers push continuously (ALU regs 1,2,3; MEM regs 17,18,19) from one edge -> port order 1,17,2,18,3,19 with regwrite high 6 consecutive cycles (order 17,18,19,1,2,3 with WB_MEM_PRIO_EN).
- Hold mem_valid=1 with no drain contention blocked by DEPTH=2 fill (ALU saturating) -> mem_ready drops to 0 after 2 accepted entries; no entry lost or duplicated; ready returns to 1 the cycle after a pop.
- Push alu_reg=0, alu_data=0x1234 -> entry consumed, regwrite stays 0, pending[0]=0, idle=1 two cycles later.
- Fill both queues (4 entries), assert reset for one cycle -> regwrite=0 throughout, pending=0, both ready=1 after reset, no queued write ever appears.
- Push ALU reg 7 twice (data 0x1, 0x2) -> writes issued in order 0x1 then 0x2; pending[7] clears only after the second write leaves the port.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back scheduler for the regfile's single write port: two per-producer FIFOs with a
// round-robin arbiter. Define WB_MEM_PRIO_EN for fixed memory-first priority.

module wb_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [4:0]        push_reg,
  input  logic [DATA_W-1:0] push_data,
  output logic              ready,
  input  logic              pop,
  output logic              empty,
  output logic [4:0]        head_reg,
  output logic [DATA_W-1:0] head_data,
  output logic [31:0]       pending
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]        reg_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, offset;
  logic [CNT_W-1:0]  count;
  logic              push;

  // Ready looks only at registered occupancy, so a full queue refuses a push even while popping.
  assign ready     = !reset && (count != CNT_W'(DEPTH));
  assign push      = push_valid && ready;
  assign empty     = (count == '0);
  assign head_reg  = reg_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem[wr_ptr]  <= push_reg;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pending = '0;
    offset  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr;
      if (CNT_W'(offset) < count) pending[reg_mem[i]] = 1'b1;
    end
  end
endmodule

module regfile_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [4:0]        mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic [4:0]        writereg,
  output logic [DATA_W-1:0] writedata,
  output logic              regwrite,
  output logic [31:0]       pending,
  output logic              idle
);
  logic              alu_empty, mem_empty;
  logic [4:0]        alu_head_reg, mem_head_reg, sel_reg;
  logic [DATA_W-1:0] alu_head_data, mem_head_data, sel_data;
  logic [31:0]       alu_pending, mem_pending;
  logic              grant_alu, grant_mem;

  wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_alu_q (
    .clk(clk), .reset(reset),
    .push_valid(alu_valid), .push_reg(alu_reg), .push_data(alu_data), .ready(alu_ready),
    .pop(grant_alu), .empty(alu_empty), .head_reg(alu_head_reg), .head_data(alu_head_data),
    .pending(alu_pending)
  );

  wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem_q (
    .clk(clk), .reset(reset),
    .push_valid(mem_valid), .push_reg(mem_reg), .push_data(mem_data), .ready(mem_ready),
    .pop(grant_mem), .empty(mem_empty), .head_reg(mem_head_reg), .head_data(mem_head_data),
    .pending(mem_pending)
  );

`ifdef WB_MEM_PRIO_EN
  always_comb begin
    grant_mem = !mem_empty;
    grant_alu = mem_empty && !alu_empty;
  end
`else
  typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} producer_e;
  producer_e last_grant;

  // Reset to MEM so the ALU wins the first tie.
  always_ff @(posedge clk) begin
    if (reset)                        last_grant <= GRANT_MEM;
    else if (!alu_empty && !mem_empty) last_grant <= grant_alu ? GRANT_ALU : GRANT_MEM;
  end

  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!alu_empty && !mem_empty) begin
      grant_alu = (last_grant == GRANT_MEM);
      grant_mem = (last_grant == GRANT_ALU);
    end else begin
      grant_alu = !alu_empty;
      grant_mem = !mem_empty;
    end
  end
`endif

  always_comb begin
    sel_reg  = grant_alu ? alu_head_reg  : mem_head_reg;
    sel_data = grant_alu ? alu_head_data : mem_head_data;
  end

  // A granted write to R0 is consumed but never raises regwrite.
  always_ff @(posedge clk) begin
    if (reset) begin
      writereg  <= '0;
      writedata <= '0;
      regwrite  <= 1'b0;
    end else if (grant_alu || grant_mem) begin
      writereg  <= sel_reg;
      writedata <= sel_data;
      regwrite  <= (sel_reg != 5'd0);
    end else begin
      regwrite  <= 1'b0;
    end
  end

  always_comb begin
    pending = alu_pending | mem_pending;
    if (regwrite) pending[writereg] = 1'b1;
    pending[0] = 1'b0;
  end

  assign idle = alu_empty && mem_empty && !regwrite;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then random traffic,
// compared against a queue-based reference model of the write-back scheduler.
module tb_regfile_wb_arbiter;
  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid, mem_valid;
  logic              alu_ready, mem_ready;
  logic [4:0]        alu_reg, mem_reg, writereg;
  logic [DATA_W-1:0] alu_data, mem_data, writedata;
  logic              regwrite, idle;
  logic [31:0]       pending;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .writereg(writereg), .writedata(writedata), .regwrite(regwrite),
    .pending(pending), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]        r;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              aq[$], mq[$];
  bit                m_last_mem;
  logic [4:0]        m_wreg;
  logic [DATA_W-1:0] m_wdata;
  logic              m_rw;
  int                tests = 0;
  int                fails = 0;
  int                port_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_pending();
    logic [31:0] p = '0;
    foreach (aq[i]) p[aq[i].r] = 1'b1;
    foreach (mq[i]) p[mq[i].r] = 1'b1;
    if (m_rw) p[m_wreg] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // One clock: apply inputs, check ready, advance model and DUT, check the port.
  task automatic cycle(input logic rst, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    bit   acc_a, acc_m;
    int   g;
    ent_t e;
    reset = rst; alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    #1;
    check("alu_ready", alu_ready, !rst && aq.size() < DEPTH);
    check("mem_ready", mem_ready, !rst && mq.size() < DEPTH);
    @(posedge clk);
    if (rst) begin
      aq.delete(); mq.delete();
      m_last_mem = 1'b1; m_wreg = '0; m_wdata = '0; m_rw = 1'b0;
    end else begin
      acc_a = av && aq.size() < DEPTH;
      acc_m = mv && mq.size() < DEPTH;
      g = 0;
`ifdef WB_MEM_PRIO_EN
      if (mq.size() > 0) g = 2;
      else if (aq.size() > 0) g = 1;
`else
      if (aq.size() > 0 && mq.size() > 0) begin
        g = m_last_mem ? 1 : 2;
        m_last_mem = (g == 2);
      end else if (aq.size() > 0) g = 1;
      else if (mq.size() > 0) g = 2;
`endif
      e = '0;
      if (g == 1) e = aq.pop_front();
      if (g == 2) e = mq.pop_front();
      if (g != 0) begin
        m_wreg = e.r; m_wdata = e.d; m_rw = (e.r != 5'd0);
      end else begin
        m_rw = 1'b0;
      end
      if (acc_a) aq.push_back({ar, ad});
      if (acc_m) mq.push_back({mr, md});
    end
    #1;
    check("regwrite", regwrite, m_rw);
    check("writereg", writereg, m_wreg);
    check("writedata", writedata, m_wdata);
    check("pending", pending, exp_pending());
    check("idle", idle, aq.size() == 0 && mq.size() == 0 && !m_rw);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int   ai, mi, first_rw, last_rw;
    logic av, mv, aa, am, rst;
    int   exp_order[6];

    reset = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    alu_reg = '0; mem_reg = '0; alu_data = '0; mem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    m_last_mem = 1'b1; m_wreg = '0; m_wdata = '0; m_rw = 1'b0;

    // Reset state, then ready rises once reset drops.
    cycle(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    idle_cycle();
    check("reset_idle", idle, 1);
    check("reset_pending", pending, 0);

    // Single push: one-cycle regwrite at the following edge.
    cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    check("single_pend_after_push", pending, 32'h20);
    idle_cycle();
    check("single_regwrite", regwrite, 1);
    check("single_writereg", writereg, 5);
    check("single_writedata", writedata, 32'hDEADBEEF);
    idle_cycle();
    check("single_rw_drop", regwrite, 0);
    check("single_idle", idle, 1);

    // Both producers stream three entries each, holding valid until accepted.
    ai = 0; mi = 0; first_rw = -1; last_rw = -1;
    port_log.delete();
    for (int c = 0; c < 12; c++) begin
      av = (ai < 3); mv = (mi < 3);
      aa = av && aq.size() < DEPTH;
      am = mv && mq.size() < DEPTH;
      cycle(1'b0, av, 5'(1 + ai), 32'h100 + ai, mv, 5'(17 + mi), 32'h200 + mi);
      if (aa) ai++;
      if (am) mi++;
      if (regwrite) begin
        port_log.push_back(int'(writereg));
        if (first_rw < 0) first_rw = c;
        last_rw = c;
      end
    end
`ifdef WB_MEM_PRIO_EN
    exp_order = '{17, 18, 19, 1, 2, 3};
`else
    exp_order = '{1, 17, 2, 18, 3, 19};
`endif
    check("contention_count", port_log.size(), 6);
    check("contention_consecutive", last_rw - first_rw, 5);
    for (int k = 0; k < 6 && k < port_log.size(); k++)
      check($sformatf("contention_order[%0d]", k), port_log[k], exp_order[k]);

    // Write to R0 is consumed silently.
    cycle(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
    check("r0_pending0", pending[0], 0);
    idle_cycle();
    check("r0_no_regwrite", regwrite, 0);
    idle_cycle();
    check("r0_idle", idle, 1);

    // Fill both queues, then reset: nothing queued may ever reach the port.
    for (int c = 0; c < 3; c++)
      cycle(1'b0, 1'b1, 5'(8 + c), 32'h300 + c, 1'b1, 5'(24 + c), 32'h400 + c);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int c = 0; c < 4; c++) begin
      idle_cycle();
      check("postreset_no_write", regwrite, 0);
      check("postreset_pending", pending, 0);
      check("postreset_alu_ready", alu_ready, 1);
    end

    // Duplicate destination keeps pending until the last write leaves.
    cycle(1'b0, 1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0);
    check("dup_first_data", writedata, 32'h1);
    check("dup_pend_mid", pending[7], 1);
    idle_cycle();
    check("dup_second_data", writedata, 32'h2);
    check("dup_pend_on_port", pending[7], 1);
    idle_cycle();
    check("dup_pend_clear", pending[7], 0);

    // Random traffic with occasional reset.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      cycle(rst, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end
    repeat (6) idle_cycle();
    check("final_idle", idle, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
